// File: rtl/mem_responder.sv
// Dual-read, single-write 16-bit word memory with two 2-stage read pipelines and a shared stall.
// Define MEM_BYPASS_EN to forward a same-edge write into a read that is sampling its data stage.
module mem_responder #(
    parameter int unsigned DEPTH = 32768,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ren0,
    input  logic [AW-1:0] raddr0,
    output logic [15:0]   rdata0,
    output logic          rvalid0,
    output logic          rerr0,
    input  logic          ren1,
    input  logic [AW-1:0] raddr1,
    output logic [15:0]   rdata1,
    output logic          rvalid1,
    output logic          rerr1,
    input  logic          hold,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata
);

    localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    logic [15:0] mem_q [DEPTH];

    logic          s1_req0_q, s1_req1_q;
    logic [AW-1:0] s1_addr0_q, s1_addr1_q;
    logic          s2_valid0_q, s2_valid1_q;
    logic          s2_err0_q, s2_err1_q;
    logic [15:0]   s2_data0_q, s2_data1_q;

    logic        w_ok;
    logic        rd_oor0, rd_oor1;
    logic [15:0] rd_data0_d, rd_data1_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DepthW;
    endfunction

    assign w_ok = wen && in_range(waddr);

    // Out-of-range reads return zero rather than an aliased word.
    always_comb begin
        rd_oor0    = !in_range(s1_addr0_q);
        rd_oor1    = !in_range(s1_addr1_q);
        rd_data0_d = rd_oor0 ? 16'h0000 : mem_q[s1_addr0_q[IdxW-1:0]];
        rd_data1_d = rd_oor1 ? 16'h0000 : mem_q[s1_addr1_q[IdxW-1:0]];
`ifdef MEM_BYPASS_EN
        if (w_ok && (waddr == s1_addr0_q)) begin
            rd_data0_d = wdata;
        end
        if (w_ok && (waddr == s1_addr1_q)) begin
            rd_data1_d = wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_req0_q   <= 1'b0;
            s1_req1_q   <= 1'b0;
            s1_addr0_q  <= '0;
            s1_addr1_q  <= '0;
            s2_valid0_q <= 1'b0;
            s2_valid1_q <= 1'b0;
            s2_err0_q   <= 1'b0;
            s2_err1_q   <= 1'b0;
            s2_data0_q  <= 16'h0000;
            s2_data1_q  <= 16'h0000;
        end else if (!hold) begin
            s1_req0_q   <= ren0;
            s1_req1_q   <= ren1;
            s1_addr0_q  <= raddr0;
            s1_addr1_q  <= raddr1;
            s2_valid0_q <= s1_req0_q;
            s2_valid1_q <= s1_req1_q;
            s2_err0_q   <= rd_oor0;
            s2_err1_q   <= rd_oor1;
            s2_data0_q  <= rd_data0_d;
            s2_data1_q  <= rd_data1_d;
        end
    end

    // The array is deliberately outside reset; writes still commit while reads are held.
    always_ff @(posedge clk) begin
        if (w_ok) begin
            mem_q[waddr[IdxW-1:0]] <= wdata;
        end
    end

    assign rdata0  = s2_data0_q;
    assign rvalid0 = s2_valid0_q;
    assign rerr0   = s2_err0_q & s2_valid0_q;
    assign rdata1  = s2_data1_q;
    assign rvalid1 = s2_valid1_q;
    assign rerr1   = s2_err1_q & s2_valid1_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses, a negedge monitor checks.
// Expected data for the write-race case depends on MEM_BYPASS_EN.
module tb_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 15;

    logic          clk, rst_n;
    logic          ren0, ren1, hold, wen;
    logic [AW-1:0] raddr0, raddr1, waddr;
    logic [15:0]   wdata, rdata0, rdata1;
    logic          rvalid0, rvalid1, rerr0, rerr1;

    mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ren0    (ren0),
        .raddr0  (raddr0),
        .rdata0  (rdata0),
        .rvalid0 (rvalid0),
        .rerr0   (rerr0),
        .ren1    (ren1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .rerr1   (rerr1),
        .hold    (hold),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick     = 0;
    logic held_edge = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endfunction

    // tick counts non-held edges, so a request is due exactly two ticks after issue.
    always @(posedge clk) begin
        held_edge <= hold;
        if (rst_n && !hold) tick <= tick + 1;
    end

    always @(negedge clk) begin
        if (rst_n && !held_edge) begin
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    chk("p0_unexpected_valid", 32'(rvalid0), 32'd0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("p0_data", 32'(rdata0), 32'(e.d));
                    chk("p0_err", 32'(rerr0), 32'(e.e));
                    chk("p0_latency", tick, e.due);
                end
            end else begin
                chk("p0_err_without_valid", 32'(rerr0), 32'd0);
            end
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    chk("p1_unexpected_valid", 32'(rvalid1), 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("p1_data", 32'(rdata1), 32'(e.d));
                    chk("p1_err", 32'(rerr1), 32'(e.e));
                    chk("p1_latency", tick, e.due);
                end
            end else begin
                chk("p1_err_without_valid", 32'(rerr1), 32'd0);
            end
        end
    end

    task automatic exp0(input logic [15:0] d, input logic e);
        q0.push_back('{d: d, e: e, due: tick + 2});
    endtask

    task automatic exp1(input logic [15:0] d, input logic e);
        q1.push_back('{d: d, e: e, due: tick + 2});
    endtask

    task automatic step(input logic r0, input logic [AW-1:0] a0, input logic r1,
                        input logic [AW-1:0] a1, input logic w, input logic [AW-1:0] wa,
                        input logic [15:0] wd, input logic h);
        ren0 = r0; raddr0 = a0; ren1 = r1; raddr1 = a1;
        wen = w; waddr = wa; wdata = wd; hold = h;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 16'h0, 0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        step(0, 0, 0, 0, 1, a, d, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hold = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        ren0 = 1'b1; raddr0 = 15'd5; ren1 = 1'b1; raddr1 = 15'd5;

        // Requests while in reset must never produce output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rvalid0", 32'(rvalid0), 32'd0);
            chk("rst_rvalid1", 32'(rvalid1), 32'd0);
            chk("rst_rdata0", 32'(rdata0), 32'h0);
            chk("rst_rdata1", 32'(rdata1), 32'h0);
            chk("rst_rerr0", 32'(rerr0), 32'd0);
        end
        ren0 = 1'b0; ren1 = 1'b0; rst_n = 1'b1;
        #1;
        chk("post_rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("post_rst_rdata1", 32'(rdata1), 32'h0);

        // Preload through the write port.
        wr(5, 16'h1234);
        for (int i = 0; i < 4; i++) wr(AW'(i), 16'h0100 + 16'(i));
        wr(4, 16'h4444);
        wr(7, 16'hBEEF);
        wr(9, 16'h0001);

        exp0(16'h1234, 0);
        step(1, 5, 0, 0, 0, 0, 16'h0, 0);
        idle(2);

        // Back-to-back streaming on port 0.
        for (int i = 0; i < 4; i++) begin
            exp0(16'h0100 + 16'(i), 0);
            step(1, AW'(i), 0, 0, 0, 0, 16'h0, 0);
        end
        idle(3);

        // Stall for three edges with a read in S1.
        exp0(16'hBEEF, 0);
        step(1, 7, 0, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 16'h0, 1);
            @(negedge clk);
            chk("hold_rvalid0", 32'(rvalid0), 32'd0);
        end
        idle(3);

        // Write racing a read's data stage.
`ifdef MEM_BYPASS_EN
        exp1(16'hAAAA, 0);
`else
        exp1(16'h0001, 0);
`endif
        step(0, 0, 1, 9, 0, 0, 16'h0, 0);
        exp1(16'hAAAA, 0);
        step(0, 0, 1, 9, 1, 9, 16'hAAAA, 0);
        idle(3);

        // Out-of-range read and a dropped out-of-range write that would alias word 4.
        exp0(16'h0000, 1);
        step(1, 20, 0, 0, 0, 0, 16'h0, 0);
        wr(20, 16'hFFFF);
        exp0(16'h4444, 0);
        step(1, 4, 0, 0, 0, 0, 16'h0, 0);
        idle(3);

        // Both ports on the same word in the same cycle.
        wr(3, 16'h5A5A);
        exp0(16'h5A5A, 0);
        exp1(16'h5A5A, 0);
        step(1, 3, 1, 3, 0, 0, 16'h0, 0);
        idle(1);

        // Reset mid-operation drops rvalid immediately but keeps memory.
        exp0(16'h1234, 0);
        step(1, 5, 0, 0, 0, 0, 16'h0, 0);
        idle(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("async_rst_rdata0", 32'(rdata0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp0(16'h1234, 0);
        exp1(16'hAAAA, 0);
        step(1, 5, 1, 9, 0, 0, 16'h0, 0);
        idle(4);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
